// File: rtl/cic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cic_pkg
// Description : Shared CIC width/gain helpers for the decimator and interpolator.
// Revision    : 1.0
// ============================================================================
package cic_pkg;

    function automatic int clog2_l(input longint v);
        int r = 0;
        for (int i = 0; i < 62; i++)
            if ((64'sd1 <<< i) < v) r = i + 1;
        return r;
    endfunction

    function automatic longint ipow(input longint b, input int e);
        longint p = 1;
        for (int i = 0; i < e; i++) p = p * b;
        return p;
    endfunction

    // DC gain of an interpolator: (R*M)^N / R.
    function automatic longint cic_gain(input int r, input int m, input int n);
        return ipow(longint'(r * m), n) / longint'(r);
    endfunction

    function automatic int w_c(input int inp_dw, input int j);
        return inp_dw + j;
    endfunction

    function automatic int w_max(input int inp_dw, input int r, input int m, input int n);
        int a = inp_dw + clog2_l(cic_gain(r, m, n));
        int b = inp_dw + n;
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cic_i_if.sv
`default_nettype none
// ============================================================================
// Module      : cic_i_if
// Description : Sample-in / sample-out bundle of the CIC interpolator.
// Revision    : 1.0
// ============================================================================
interface cic_i_if #(
    parameter int INP_DW = 18,
    parameter int OUT_DW = 18
);
    logic signed [INP_DW-1:0] inp_samp_data;
    logic                     inp_samp_str;
    logic                     inp_samp_rdy;
    logic                     out_samp_en;
    logic signed [OUT_DW-1:0] out_samp_data;
    logic                     out_samp_str;
    logic                     overrun;
    logic                     underrun;

    modport master (
        output inp_samp_data, inp_samp_str, out_samp_en,
        input  inp_samp_rdy, out_samp_data, out_samp_str, overrun, underrun
    );

    modport slave (
        input  inp_samp_data, inp_samp_str, out_samp_en,
        output inp_samp_rdy, out_samp_data, out_samp_str, overrun, underrun
    );
endinterface
`default_nettype wire

// File: rtl/cic_comb.sv
`default_nettype none
// ============================================================================
// Module      : cic_comb
// Description : One comb stage, y = x - x[n-M], advancing only on valid samples.
// Revision    : 1.1
// ============================================================================
module cic_comb #(
    parameter int IW = 16,
    parameter int OW = 17,
    parameter int M  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_vld,
    input  logic signed [IW-1:0] i_data,
    output logic                 o_vld,
    output logic signed [OW-1:0] o_data
);
    logic signed [IW-1:0] r_dly [M];
    logic signed [OW-1:0] w_x;
    logic signed [OW-1:0] w_d;

    assign w_x = OW'(i_data);
    assign w_d = OW'(r_dly[M-1]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_vld  <= 1'b0;
            o_data <= '0;
            for (int i = 0; i < M; i++) r_dly[i] <= '0;
        end else begin
            o_vld <= i_vld;
            if (i_vld) begin
                o_data   <= w_x - w_d;
                r_dly[0] <= i_data;
                for (int i = 1; i < M; i++) r_dly[i] <= r_dly[i-1];
            end
        end
    end
endmodule
`default_nettype wire

// File: rtl/cic_integrator.sv
`default_nettype none
// ============================================================================
// Module      : cic_integrator
// Description : Wrapping accumulator; o_sum is the value this tick stores.
// Revision    : 1.1
// ============================================================================
module cic_integrator #(
    parameter int W = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_en,
    input  logic signed [W-1:0] i_data,
    output logic signed [W-1:0] o_sum
);
    logic signed [W-1:0] r_acc;

    assign o_sum = r_acc + i_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)     r_acc <= '0;
        else if (i_en) r_acc <= o_sum;
    end
endmodule
`default_nettype wire

// File: rtl/cic_upsampler.sv
`default_nettype none
// ============================================================================
// Module      : cic_upsampler
// Description : Pending-sample slot, zero-insert phase counter, rdy and
//               overrun/underrun flags between the comb and integrator sections.
// Revision    : 1.0
// ============================================================================
module cic_upsampler
    import cic_pkg::*;
#(
    parameter int IW = 19,
    parameter int W  = 20,
    parameter int R  = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_comb_vld,
    input  logic signed [IW-1:0] i_comb_data,
    input  logic                 i_inflight,
    input  logic                 i_str,
    input  logic                 i_en,
    output logic                 o_rdy,
    output logic signed [W-1:0]  o_data,
    output logic                 o_overrun,
    output logic                 o_underrun
);
    localparam int PW = clog2_l(longint'(R));

    logic [PW-1:0]        r_phase;
    logic signed [IW-1:0] r_pend_data;
    logic                 r_pend_vld;
    logic                 w_ph0;
    logic                 w_take_new;
    logic signed [IW-1:0] w_sel;

    assign w_ph0      = i_en && (r_phase == '0);
    assign w_take_new = w_ph0 && !r_pend_vld && i_comb_vld;
    assign o_rdy      = !i_inflight && !r_pend_vld;
    assign o_data     = W'(w_sel);

    // A comb result arriving on a phase-0 tick bypasses the pending slot.
    always_comb begin
        w_sel = '0;
        if (w_ph0) begin
            if (r_pend_vld)      w_sel = r_pend_data;
            else if (i_comb_vld) w_sel = i_comb_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_phase     <= '0;
            r_pend_data <= '0;
            r_pend_vld  <= 1'b0;
            o_overrun   <= 1'b0;
            o_underrun  <= 1'b0;
        end else begin
            if (i_en)
                r_phase <= (r_phase == PW'(R - 1)) ? '0 : r_phase + 1'b1;
            if (w_ph0 && r_pend_vld) begin
                r_pend_vld <= 1'b0;
            end else if (i_comb_vld && !w_take_new) begin
                r_pend_vld  <= 1'b1;
                r_pend_data <= i_comb_data;
            end
            o_overrun  <= i_str && !o_rdy;
            o_underrun <= w_ph0 && !r_pend_vld && !i_comb_vld;
        end
    end
endmodule
`default_nettype wire

// File: rtl/cic_i.sv
`default_nettype none
// ============================================================================
// Module      : cic_i
// Description : CIC interpolator: low-rate combs, zero-insert upsampler and
//               high-rate integrators clocked by out_samp_en ticks.
// Revision    : 1.0
// ============================================================================
module cic_i
    import cic_pkg::*;
#(
    parameter int INP_DW = 18,
    parameter int OUT_DW = 18,
    parameter int CIC_R  = 10,
    parameter int CIC_N  = 7,
    parameter int CIC_M  = 1
) (
    input  logic   clk,
    input  logic   reset,
    cic_i_if.slave bus
);
    localparam int W  = w_max(INP_DW, CIC_R, CIC_M, CIC_N);
    localparam int WC = w_c(INP_DW, CIC_N);

    logic [CIC_N:0]       w_cv;
    logic signed [WC-1:0] w_cd [CIC_N+1];
    logic signed [W-1:0]  w_is [CIC_N+1];
    logic                 w_rdy;
    logic signed [OUT_DW-1:0] r_out;
    logic                 r_str;

    assign w_cv[0] = bus.inp_samp_str && w_rdy;
    assign w_cd[0] = WC'(bus.inp_samp_data);

    for (genvar j = 1; j <= CIC_N; j++) begin : g_comb
        logic signed [INP_DW+j-1:0] w_o;
        cic_comb #(.IW(INP_DW + j - 1), .OW(INP_DW + j), .M(CIC_M)) u_comb (
            .clk    (clk),
            .reset  (reset),
            .i_vld  (w_cv[j-1]),
            .i_data (w_cd[j-1][INP_DW+j-2:0]),
            .o_vld  (w_cv[j]),
            .o_data (w_o)
        );
        assign w_cd[j] = WC'(w_o);
    end

    cic_upsampler #(.IW(WC), .W(W), .R(CIC_R)) u_ups (
        .clk         (clk),
        .reset       (reset),
        .i_comb_vld  (w_cv[CIC_N]),
        .i_comb_data (w_cd[CIC_N]),
        .i_inflight  (|w_cv[CIC_N:1]),
        .i_str       (bus.inp_samp_str),
        .i_en        (bus.out_samp_en),
        .o_rdy       (w_rdy),
        .o_data      (w_is[0]),
        .o_overrun   (bus.overrun),
        .o_underrun  (bus.underrun)
    );

    // Integrator sums chain combinationally so each tick lands in r_out directly.
    for (genvar j = 0; j < CIC_N; j++) begin : g_int
        cic_integrator #(.W(W)) u_int (
            .clk    (clk),
            .reset  (reset),
            .i_en   (bus.out_samp_en),
            .i_data (w_is[j]),
            .o_sum  (w_is[j+1])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_out <= '0;
            r_str <= 1'b0;
        end else begin
            r_str <= bus.out_samp_en;
            if (bus.out_samp_en) r_out <= w_is[CIC_N][W-1 -: OUT_DW];
        end
    end

    assign bus.inp_samp_rdy  = w_rdy;
    assign bus.out_samp_data = r_out;
    assign bus.out_samp_str  = r_str;
endmodule
`default_nettype wire

// File: tb/tb_cic_i.sv
`default_nettype none
// ============================================================================
// Module      : tb_cic_i
// Description : Scoreboard bench for cic_i (N=3, R=4, M=1, 16-bit in, 20-bit out).
// Revision    : 1.0
// ============================================================================
module tb_cic_i;
    localparam int IDW = 16;
    localparam int ODW = 20;
    localparam int R   = 4;
    localparam int N   = 3;
    localparam int M   = 1;
    localparam int BW  = 20;   // 16 + log2(4^3/4) = 20 > 16 + 3

    typedef struct { longint v; longint t; } fl_t;

    logic clk   = 1'b0;
    logic reset = 1'b0;

    cic_i_if #(.INP_DW(IDW), .OUT_DW(ODW)) bus ();

    cic_i #(.INP_DW(IDW), .OUT_DW(ODW), .CIC_R(R), .CIC_N(N), .CIC_M(M)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int     n_chk = 0;
    int     n_fail = 0;
    longint exp_q[$];
    fl_t    flight[$];
    longint hist[$];
    longint cap[$];
    longint acc_m [N];
    longint pend, hold_exp, m_lv, m_x;
    bit     pend_v, exp_ovr, exp_udr, exp_str, m_rdy, m_load, m_cons, m_acc;
    int     phase;
    longint cyc = 0;
    int     ovr_cnt = 0;
    int     udr_cnt = 0;
    longint imp [11] = '{1, 3, 6, 10, 12, 12, 10, 6, 3, 1, 0};

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic longint wrapw(input longint v, input int w);
        longint md = 64'sd1 <<< w;
        longint r  = v & (md - 1);
        if (r >= (md >>> 1)) r = r - md;
        return r;
    endfunction

    // Comb cascade = (1 - z^-M)^N over accepted samples: binomial weights.
    function automatic longint comb_val();
        longint y = 0;
        longint c = 1;
        int     n = hist.size() - 1;
        for (int k = 0; k <= N; k++) begin
            if (n - k * M >= 0) y += ((k % 2) ? -c : c) * hist[n - k * M];
            c = c * (N - k) / (k + 1);
        end
        return y;
    endfunction

    function automatic void model_clear();
        flight.delete(); hist.delete(); exp_q.delete();
        for (int k = 0; k < N; k++) acc_m[k] = 0;
        pend = 0; pend_v = 0; phase = 0;
        exp_ovr = 0; exp_udr = 0; exp_str = 0; hold_exp = 0;
    endfunction

    // Reference model: checks the flags for this cycle, then predicts the next edge.
    always @(negedge clk) begin
        if (reset) begin
            model_clear();
        end else begin
            m_rdy = (flight.size() == 0) && !pend_v;
            check("inp_samp_rdy", longint'(bus.inp_samp_rdy), longint'(m_rdy));
            check("overrun", longint'(bus.overrun), longint'(exp_ovr));
            check("underrun", longint'(bus.underrun), longint'(exp_udr));
            check("out_samp_str", longint'(bus.out_samp_str), longint'(exp_str));

            m_acc   = bus.inp_samp_str && m_rdy;
            exp_ovr = bus.inp_samp_str && !m_rdy;
            exp_udr = 0; m_load = 0; m_cons = 0; m_lv = 0;
            if (flight.size() > 0 && flight[0].t == cyc) begin
                m_load = 1; m_lv = flight[0].v; flight.delete(0);
            end
            if (bus.out_samp_en) begin
                m_x = 0;
                if (phase == 0) begin
                    if (pend_v)      begin m_x = pend; pend_v = 0; end
                    else if (m_load) begin m_x = m_lv; m_cons = 1; end
                    else             exp_udr = 1;
                end
                phase = (phase + 1) % R;
                for (int k = 0; k < N; k++)
                    acc_m[k] = wrapw(acc_m[k] + ((k == 0) ? m_x : acc_m[k-1]), BW);
                exp_q.push_back(wrapw(acc_m[N-1] >>> (BW - ODW), ODW));
            end
            if (m_load && !m_cons) begin pend = m_lv; pend_v = 1; end
            if (m_acc) begin
                hist.push_back(longint'(bus.inp_samp_data));
                flight.push_back('{comb_val(), cyc + N});
            end
            exp_str = bus.out_samp_en;
            cyc++;
        end
    end

    // Monitor: pops the expected sample whenever the DUT strobes one out.
    always @(negedge clk) begin
        if (!reset) begin
            if (bus.overrun)  ovr_cnt++;
            if (bus.underrun) udr_cnt++;
            if (bus.out_samp_str) begin
                cap.push_back(longint'(bus.out_samp_data));
                if (exp_q.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL out_samp_data: got %0d, expected no output", bus.out_samp_data);
                end else begin
                    hold_exp = exp_q.pop_front();
                    check("out_samp_data", longint'(bus.out_samp_data), hold_exp);
                end
            end else begin
                check("out_hold", longint'(bus.out_samp_data), hold_exp);
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic send(input logic signed [IDW-1:0] d);
        int guard = 0;
        while (!bus.inp_samp_rdy && guard < 200) begin tick(); guard++; end
        if (guard >= 200) begin
            n_chk++; n_fail++;
            $display("FAIL rdy_timeout: inp_samp_rdy 0 for %0d cycles, expected 1", guard);
        end
        bus.inp_samp_data = d;
        bus.inp_samp_str  = 1'b1;
        tick();
        bus.inp_samp_str  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #3;
        reset = 1'b1; #1;
        check("rst_out_data", longint'(bus.out_samp_data), 0);
        check("rst_out_str", longint'(bus.out_samp_str), 0);
        check("rst_overrun", longint'(bus.overrun), 0);
        check("rst_underrun", longint'(bus.underrun), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk); #1;
        check("rdy_after_reset", longint'(bus.inp_samp_rdy), 1);
        ovr_cnt = 0; udr_cnt = 0; cap.delete();
        @(posedge clk); #1;
    endtask

    task automatic check_tail(input string name, input longint v);
        if (cap.size() < 4) begin
            n_chk++; n_fail++;
            $display("FAIL %s: got %0d outputs, expected at least 4", name, cap.size());
        end else begin
            for (int k = 1; k <= 4; k++) check(name, cap[cap.size() - k], v);
        end
    endtask

    initial begin
        int idx;
        bus.inp_samp_data = '0;
        bus.inp_samp_str  = 1'b0;
        bus.out_samp_en   = 1'b0;
        do_reset();

        // Impulse with a dropped second strobe.
        bus.out_samp_en = 1'b1;
        send(16'sd1);
        bus.inp_samp_data = 16'sd5;
        bus.inp_samp_str  = 1'b1;
        tick();
        bus.inp_samp_str  = 1'b0;
        repeat (5) send(16'sd0);
        repeat (20) tick();
        check("overrun_count", ovr_cnt, 1);
        idx = -1;
        for (int i = 0; i < cap.size(); i++) if (cap[i] != 0) begin idx = i; break; end
        for (int k = 0; k < 11; k++) begin
            if (idx >= 0 && idx + k < cap.size())
                check($sformatf("impulse[%0d]", k), cap[idx + k], imp[k]);
            else begin
                n_chk++; n_fail++;
                $display("FAIL impulse[%0d]: got no output, expected %0d", k, imp[k]);
            end
        end

        // Step gain.
        do_reset();
        repeat (12) send(16'sd1000);
        repeat (12) tick();
        check_tail("step_gain", 16000);

        // Underrun window of 8 ticks with nothing pending.
        @(negedge clk); #1;
        udr_cnt = 0;
        repeat (8) @(negedge clk);
        #1;
        check("underrun_count", udr_cnt, 2);
        @(posedge clk); #1;
        repeat (6) send(16'sd0);
        repeat (20) tick();
        check_tail("decay", 0);

        // Reset in the middle of a burst.
        repeat (3) send(16'sd1000);
        do_reset();

        // Full-scale negative input.
        repeat (12) send(-16'sd32768);
        repeat (12) tick();
        check_tail("wrap", -524288);

        // Random traffic, occasional overruns and irregular ticks.
        for (int i = 0; i < 2000; i++) begin
            bus.out_samp_en = ($urandom_range(0, 3) != 0);
            if (bus.inp_samp_rdy) bus.inp_samp_str = ($urandom_range(0, 1) == 1);
            else                  bus.inp_samp_str = ($urandom_range(0, 9) == 0);
            bus.inp_samp_data = IDW'($urandom);
            tick();
        end
        bus.inp_samp_str = 1'b0;
        bus.out_samp_en  = 1'b0;
        repeat (3) tick();
        check("queue_drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "timeout");
    end
endmodule
`default_nettype wire
